// File: rtl/dm_bytelane_ctrl.sv
// Byte-addressable data memory for the MIPS datapath: byte/half/word stores, sign/zero-extended
// loads, alignment and range faults, registered read with valid strobe and a post-reset clear engine.
module dm_bytelane_ctrl #(
  parameter int          DEPTH          = 256,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  parameter logic [31:0] ERR_CODE       = 32'h0000DEAD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  output logic        ready,
  output logic        rvalid,
  output logic [31:0] rd,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t        state;
  logic [AW-1:0] clr_idx;
  logic [31:0]   mem [DEPTH];

  logic          accept;
  logic          fault;
  logic [31:0]   word_addr;
  logic [AW-1:0] widx;
  logic [1:0]    lane;
  logic [3:0]    be;
  logic [31:0]   wdata;
  logic [31:0]   shifted;
  logic [31:0]   load_val;

  assign accept    = req && ready;
  assign word_addr = {2'b00, addr[31:2]};
  assign widx      = word_addr[AW-1:0];
  assign lane      = addr[1:0];

  always_comb begin
    fault = 1'b0;
    case (size)
      2'b00:   fault = 1'b0;
      2'b01:   fault = addr[0];
      2'b10:   fault = (addr[1:0] != 2'b00);
      default: fault = 1'b1;
    endcase
    // Out-of-range indices fault instead of aliasing onto a low word
    if (word_addr >= 32'(DEPTH)) fault = 1'b1;
  end

  always_comb begin
    be    = '0;
    wdata = wd;
    case (size)
      2'b00: begin
        be    = 4'b0001 << lane;
        wdata = {4{wd[7:0]}};
      end
      2'b01: begin
        be    = addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{wd[15:0]}};
      end
      default: be = 4'b1111;
    endcase
  end

  // Lane data is shifted down to bit 0; aligned halves land on [15:0] as well
  always_comb begin
    shifted  = mem[widx] >> {lane, 3'b000};
    load_val = mem[widx];
    case (size)
      2'b00:   load_val = sign_ext ? {{24{shifted[7]}}, shifted[7:0]}
                                   : {24'h000000, shifted[7:0]};
      2'b01:   load_val = sign_ext ? {{16{shifted[15]}}, shifted[15:0]}
                                   : {16'h0000, shifted[15:0]};
      default: load_val = mem[widx];
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == S_CLEAR) begin
      mem[clr_idx] <= '0;
    end else if (accept && we && !fault) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
      clr_idx <= '0;
      ready   <= 1'b0;
      rvalid  <= 1'b0;
      err     <= 1'b0;
      rd      <= '0;
    end else begin
      rvalid <= 1'b0;
      err    <= 1'b0;
      case (state)
        S_CLEAR: begin
          ready   <= 1'b0;
          clr_idx <= clr_idx + 1'b1;
          if (clr_idx == AW'(DEPTH - 1)) begin
            state   <= S_IDLE;
            ready   <= 1'b1;
            clr_idx <= '0;
          end
        end
        S_IDLE: begin
          ready <= 1'b1;
          if (accept) begin
            if (fault) begin
              err <= 1'b1;
              if (!we) begin
                rvalid <= 1'b1;
                rd     <= ERR_CODE;
              end
            end else if (!we) begin
              rvalid <= 1'b1;
              rd     <= load_val;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_bytelane_ctrl.sv
// Directed bench for dm_bytelane_ctrl: expected responses are queued as requests are driven and
// compared one cycle later; reset/clear timing is checked on a clearing and a non-clearing instance.
module tb_dm_bytelane_ctrl;

  localparam int DEPTH = 256;
  localparam logic [1:0] SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_X = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0, we = 1'b0, sign_ext = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = '0, wd = '0;
  logic        ready, rvalid, err;
  logic [31:0] rd;

  logic        nc_req = 1'b0, nc_we = 1'b0, nc_sx = 1'b0;
  logic [1:0]  nc_size = 2'b00;
  logic [31:0] nc_addr = '0, nc_wd = '0;
  logic        nc_ready, nc_rvalid, nc_err;
  logic [31:0] nc_rd;

  int checks = 0;
  int errors = 0;
  int cnt;

  typedef struct {
    string       tag;
    logic        rv;
    logic        er;
    logic [31:0] rdv;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  dm_bytelane_ctrl #(.DEPTH(DEPTH), .CLEAR_ON_RESET(1'b1), .ERR_CODE(32'h0000DEAD)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wd(wd), .ready(ready), .rvalid(rvalid), .rd(rd), .err(err));

  dm_bytelane_ctrl #(.DEPTH(DEPTH), .CLEAR_ON_RESET(1'b0), .ERR_CODE(32'h0000DEAD)) u_nc (
    .clk(clk), .rst_n(rst_n), .req(nc_req), .we(nc_we), .size(nc_size), .sign_ext(nc_sx),
    .addr(nc_addr), .wd(nc_wd), .ready(nc_ready), .rvalid(nc_rvalid), .rd(nc_rd), .err(nc_err));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, ".rvalid"}, {31'd0, rvalid}, {31'd0, e.rv});
      chk({e.tag, ".err"}, {31'd0, err}, {31'd0, e.er});
      if (e.rv) chk({e.tag, ".rd"}, rd, e.rdv);
    end
  endtask

  task automatic step(input string tag, input logic r, input logic w, input logic [1:0] sz,
                      input logic sx, input logic [31:0] a, input logic [31:0] d,
                      input logic erv, input logic eer, input logic [31:0] erd);
    exp_t e;
    @(negedge clk);
    pop_check();
    req = r; we = w; size = sz; sign_ext = sx; addr = a; wd = d;
    e.tag = tag; e.rv = erv; e.er = eer; e.rdv = erd;
    sb.push_back(e);
  endtask

  task automatic idle();
    step("idle", 1'b0, 1'b0, SZ_W, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  // Counts rising edges from release until ready rises, bounded
  task automatic release_and_count(output int n);
    n = 0;
    rst_n = 1'b1;
    while (!ready && n < 1000) begin
      @(negedge clk);
      n++;
      if (n == 1) chk("nc_ready_first_cycle", {31'd0, nc_ready}, 32'd1);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst.ready", {31'd0, ready}, 32'd0);
    chk("rst.rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst.err", {31'd0, err}, 32'd0);
    chk("rst.rd", rd, 32'h0);
    chk("rst.nc_ready", {31'd0, nc_ready}, 32'd0);
    release_and_count(cnt);
    chk("clear_cycles", cnt, DEPTH);

    step("lw_last",     1, 0, SZ_W, 0, 32'h3FC, 32'h0,        1, 0, 32'h0);
    step("sw_20",       1, 1, SZ_W, 0, 32'h20,  32'h11223344, 0, 0, 32'h0);
    step("sb_23",       1, 1, SZ_B, 0, 32'h23,  32'h00000080, 0, 0, 32'h0);
    step("lh_22",       1, 0, SZ_H, 1, 32'h22,  32'h0,        1, 0, 32'hFFFF8022);
    step("lbu_20",      1, 0, SZ_B, 0, 32'h20,  32'h0,        1, 0, 32'h00000044);
    step("lw_20",       1, 0, SZ_W, 0, 32'h20,  32'h0,        1, 0, 32'h80223344);
    step("lb_23",       1, 0, SZ_B, 1, 32'h23,  32'h0,        1, 0, 32'hFFFFFF80);
    step("lhu_22",      1, 0, SZ_H, 0, 32'h22,  32'h0,        1, 0, 32'h00008022);
    step("lb_21",       1, 0, SZ_B, 1, 32'h21,  32'h0,        1, 0, 32'h00000033);
    step("lw_misalign", 1, 0, SZ_W, 0, 32'h22,  32'h0,        1, 1, 32'h0000DEAD);
    step("sh_misalign", 1, 1, SZ_H, 0, 32'h21,  32'h0000BEEF, 0, 1, 32'h0);
    step("lw_20_again", 1, 0, SZ_W, 0, 32'h20,  32'h0,        1, 0, 32'h80223344);
    step("sw_range",    1, 1, SZ_W, 0, 32'h400, 32'hCAFEF00D, 0, 1, 32'h0);
    step("lw_0",        1, 0, SZ_W, 0, 32'h0,   32'h0,        1, 0, 32'h0);
    step("lx_illegal",  1, 0, SZ_X, 0, 32'h24,  32'h0,        1, 1, 32'h0000DEAD);
    step("sw_40",       1, 1, SZ_W, 0, 32'h40,  32'hA5A5A5A5, 0, 0, 32'h0);
    step("lw_40",       1, 0, SZ_W, 0, 32'h40,  32'h0,        1, 0, 32'hA5A5A5A5);
    step("lw_44",       1, 0, SZ_W, 0, 32'h44,  32'h0,        1, 0, 32'h0);
    step("sb_3ff",      1, 1, SZ_B, 0, 32'h3FF, 32'h000000FE, 0, 0, 32'h0);
    step("lw_3fc",      1, 0, SZ_W, 1, 32'h3FC, 32'h0,        1, 0, 32'hFE000000);
    step("lh_3fe",      1, 0, SZ_H, 1, 32'h3FE, 32'h0,        1, 0, 32'hFFFFFE00);
    idle();
    @(negedge clk);
    pop_check();
    chk("rd_held", rd, 32'hFFFFFE00);

    // Reset lands just after a load is accepted: its rvalid must never appear
    req = 1; we = 0; size = SZ_W; sign_ext = 0; addr = 32'h20;
    @(posedge clk);
    #1 rst_n = 1'b0;
    req = 0;
    @(negedge clk);
    chk("rst_load.rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_load.rd", rd, 32'h0);
    chk("rst_load.ready", {31'd0, ready}, 32'd0);
    repeat (2) @(negedge clk);
    release_and_count(cnt);
    chk("clear_cycles_2", cnt, DEPTH);
    step("lw_20_cleared", 1, 0, SZ_W, 0, 32'h20, 32'h0, 1, 0, 32'h0);
    idle();
    @(negedge clk);
    pop_check();

    // Reset in the middle of the clear sequence restarts it in full
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midclear.ready", {31'd0, ready}, 32'd0);
    release_and_count(cnt);
    chk("clear_cycles_3", cnt, DEPTH);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
